// File: rtl/apb_regfile_pkg.sv
// Shared definitions for the parametrised APB register file: FSM state
// encoding, wait-counter width and helpers deriving lane count and the
// byte-to-word address shift from the data width.
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Wait counter width; WAIT_CYCLES is limited to 0..15.
  localparam int CNT_W = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int addr_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_regfile_param_if.sv
// APB bus bundle between the decoder (master) and the register file (slave).
interface apb_regfile_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_param_wait_ctr.sv
// Access-phase wait-state down-counter. Loaded with WAIT_CYCLES as the setup
// phase ends, counts down once per access cycle and stops at zero; o_done
// flags terminal count.
module apb_wait_ctr
  import apb_regfile_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic i_load,
  input  logic i_dec,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load on setup, decrement while in the access phase, hold at zero.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(WAIT_CYCLES);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/apb_regfile_param.sv
// Parametrised APB slave register file with binary byte addressing,
// programmable wait states, per-register read-only protection and PSLVERR.
// Optional byte-strobe writes are enabled by defining APB_REGFILE_PSTRB_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no transfer in progress; penable without a setup is ignored
// ST_SETUP  | setup-phase cycle (psel && !penable seen while idle); it is
//           | recognised combinationally so the access phase begins at the
//           | very next edge and a zero-wait transfer takes two cycles
// ST_ACCESS | access phase; waits for the counter, completes on pready,
//           | aborts if psel drops
module apb_regfile_param
  import apb_regfile_pkg::*;
#(
  parameter int                  DATA_W      = 32,
  parameter int                  NUM_REGS    = 8,
  parameter int                  ADDR_W      = 8,
  parameter int                  WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RST_VAL     = '0
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_regfile_param_if.slave  bus
);

  localparam int                LANES    = lane_count(DATA_W);
  localparam int                SHIFT    = addr_shift(DATA_W);
  localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SHIFT) - 1);

  apb_state_e        r_state;
  apb_state_e        w_state_cur;
  apb_state_e        w_state_nxt;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic [ADDR_W-1:0] w_idx_full;
  logic [IDX_W-1:0]  w_idx;
  logic              w_oor;
  logic              w_misaligned;
  logic              w_invalid;
  logic              w_ro_hit;
  logic              w_cnt_done;
  logic              w_pready;
  logic              w_wr_commit;
  logic [LANES-1:0]  w_byte_en;
  logic              w_strb_rd_err;

  // Address decode; the index is forced to 0 when out of range so the
  // register array and read-only mask are never indexed past their end.
  assign w_idx_full   = bus.paddr >> SHIFT;
  assign w_misaligned = |(bus.paddr & LOW_MASK);
  assign w_oor        = (32'(w_idx_full) >= 32'(NUM_REGS));
  assign w_invalid    = w_oor || w_misaligned;
  assign w_idx        = w_oor ? '0 : w_idx_full[IDX_W-1:0];
  assign w_ro_hit     = !w_oor && RO_MASK[w_idx];

`ifdef APB_REGFILE_PSTRB_EN
  assign w_byte_en     = bus.pstrb;
  assign w_strb_rd_err = !bus.pwrite && (bus.pstrb != '0);
`else
  assign w_byte_en     = '1;
  assign w_strb_rd_err = 1'b0;
`endif

  // Current phase: a setup cycle is seen directly on the bus while idle.
  always_comb begin
    w_state_cur = r_state;
    if ((r_state == ST_IDLE) && bus.psel && !bus.penable) begin
      w_state_cur = ST_SETUP;
    end
  end

  // Next-state decision from the current phase.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (w_state_cur)
      ST_IDLE:   w_state_nxt = ST_IDLE;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (!bus.psel || w_pready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  apb_wait_ctr #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_ctr (
    .pclk     (pclk),
    .preset_n (preset_n),
    .i_load   (w_state_cur == ST_SETUP),
    .i_dec    (r_state == ST_ACCESS),
    .o_done   (w_cnt_done)
  );

  assign w_pready    = (r_state == ST_ACCESS) && w_cnt_done && bus.psel && bus.penable;
  assign w_wr_commit = w_pready && bus.pwrite && !w_invalid && !w_ro_hit;

  // Register array: reset to RST_VAL, byte-lane write on a clean completion.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RST_VAL;
      end
    end else if (w_wr_commit) begin
      for (int b = 0; b < LANES; b++) begin
        if (w_byte_en[b]) begin
          r_regs[w_idx][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
        end
      end
    end
  end

  assign bus.pready  = w_pready;
  assign bus.prdata  = (w_pready && !bus.pwrite && !w_invalid) ? r_regs[w_idx] : '0;
  assign bus.pslverr = w_pready &&
                       (w_invalid || (bus.pwrite && w_ro_hit) || w_strb_rd_err);

endmodule

// File: tb/tb_apb_regfile_param.sv
// Self-checking bench for apb_regfile_param: two instances (zero-wait and
// three-wait) share the bus inputs with separate selects; results are
// compared against a register-array reference model.
module tb_apb_regfile_param;

  localparam logic [7:0]  RO0  = 8'h80;
  localparam logic [7:0]  RO1  = 8'h04;
  localparam logic [31:0] RST0 = 32'h0000_0000;
  localparam logic [31:0] RST1 = 32'hC0DE_0001;
  localparam int          W0   = 0;
  localparam int          W1   = 3;

  logic        pclk;
  logic        preset_n;
  logic        psel0, psel1, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  int n_cmp;
  int n_err;

  logic [31:0] m0 [8];
  logic [31:0] m1 [8];

  apb_regfile_param_if #(.ADDR_W(8), .DATA_W(32)) if0 ();
  apb_regfile_param_if #(.ADDR_W(8), .DATA_W(32)) if1 ();

  assign if0.psel    = psel0;
  assign if0.penable = penable;
  assign if0.pwrite  = pwrite;
  assign if0.paddr   = paddr;
  assign if0.pwdata  = pwdata;
  assign if0.pstrb   = pstrb;
  assign if1.psel    = psel1;
  assign if1.penable = penable;
  assign if1.pwrite  = pwrite;
  assign if1.paddr   = paddr;
  assign if1.pwdata  = pwdata;
  assign if1.pstrb   = pstrb;

  apb_regfile_param #(
    .DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .WAIT_CYCLES(W0),
    .RO_MASK(RO0), .RST_VAL(RST0)
  ) u_dut0 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (if0.slave)
  );

  apb_regfile_param #(
    .DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .WAIT_CYCLES(W1),
    .RO_MASK(RO1), .RST_VAL(RST1)
  ) u_dut1 (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (if1.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m0[i] = RST0;
      m1[i] = RST1;
    end
  endtask

  // Reference: word-indexed array, error rules applied directly to the address.
  task automatic model_xfer(input int d, input bit wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] erd, output logic eerr);
    int          idx;
    bit          bad;
    bit          rob;
    logic [7:0]  ro;
    logic [3:0]  lanes;
    logic [31:0] cur;
    idx   = int'(addr) / 4;
    bad   = ((int'(addr) % 4) != 0) || (idx >= 8);
    ro    = (d == 0) ? RO0 : RO1;
    rob   = !bad && ro[idx];
    cur   = bad ? 32'h0 : ((d == 0) ? m0[idx] : m1[idx]);
`ifdef APB_REGFILE_PSTRB_EN
    lanes = strb;
`else
    lanes = 4'hF;
`endif
    erd  = 32'h0;
    eerr = 1'b0;
    if (wr) begin
      eerr = bad || rob;
      if (!eerr) begin
        for (int b = 0; b < 4; b++)
          if (lanes[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
        if (d == 0) m0[idx] = cur; else m1[idx] = cur;
      end
    end else begin
      erd  = bad ? 32'h0 : cur;
      eerr = bad;
`ifdef APB_REGFILE_PSTRB_EN
      if (strb != 4'h0) eerr = 1'b1;
`endif
    end
  endtask

  // One APB transfer on instance d; leaves psel/penable asserted after the
  // completion cycle so a following call forms a back-to-back transfer.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err,
                      output int cycles, output logic setup_rdy);
    bit got;
    @(negedge pclk);
    psel0 = (d == 0); psel1 = (d != 0);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    #1 setup_rdy = (d == 0) ? if0.pready : if1.pready;
    @(negedge pclk);
    penable = 1'b1;
    got = 1'b0; cycles = 0; rdata = '0; err = 1'b0;
    while (!got && cycles < 40) begin
      #1;
      cycles++;
      if ((d == 0) ? if0.pready : if1.pready) begin
        got   = 1'b1;
        rdata = (d == 0) ? if0.prdata : if1.prdata;
        err   = (d == 0) ? if0.pslverr : if1.pslverr;
      end else begin
        @(negedge pclk);
      end
    end
    if (!got) cycles = 99;
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, erd;
    logic        er, eer, srdy;
    int          cyc;
    preset_n = 1'b0;
    psel0 = 1'b1; psel1 = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = 8'h00; pwdata = '0; pstrb = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    #1;
    n_cmp++;
    if ({if0.pready, if0.pslverr, if1.pready, if1.pslverr} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 0000",
               {if0.pready, if0.pslverr, if1.pready, if1.pslverr});
    end
    n_cmp++;
    if ((if0.prdata | if1.prdata) !== 32'h0) begin
      n_err++;
      $display("FAIL reset_prdata: got %h/%h want 0", if0.prdata, if1.prdata);
    end
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        xfer(d, 1'b0, 8'(i * 4), 32'h0, 4'h0, rd, er, cyc, srdy);
        model_xfer(d, 1'b0, 8'(i * 4), 32'h0, 4'h0, erd, eer);
        n_cmp++;
        if (rd !== erd || er !== eer) begin
          n_err++;
          $display("FAIL reset_value d%0d r%0d: got %h/%b want %h/%b", d, i, rd, er, erd, eer);
        end
      end
      bus_idle();
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, er, cyc, srdy);
    n_cmp++;
    if (cyc !== 1 || er !== 1'b0 || srdy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_write: got cyc=%0d err=%b setup_rdy=%b want 1/0/0", cyc, er, srdy);
    end
    bus_idle();
    m0[2] = 32'hDEAD_BEEF;
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || cyc !== 1) begin
      n_err++;
      $display("FAIL basic_read: got %h err=%b cyc=%0d want deadbeef/0/1", rd, er, cyc);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    xfer(1, 1'b1, 8'h00, 32'h1357_9BDF, 4'hF, rd, er, cyc, srdy);
    n_cmp++;
    if (cyc !== W1 + 1 || er !== 1'b0) begin
      n_err++;
      $display("FAIL wait_write: got cyc=%0d err=%b want %0d/0", cyc, er, W1 + 1);
    end
    bus_idle();
    n_cmp++;
    if (if1.pready !== 1'b0) begin
      n_err++;
      $display("FAIL wait_pulse: got pready=%b want 0", if1.pready);
    end
    m1[0] = 32'h1357_9BDF;
    xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== 32'h1357_9BDF || cyc !== W1 + 1) begin
      n_err++;
      $display("FAIL wait_read: got %h cyc=%0d want 13579bdf/%0d", rd, cyc, W1 + 1);
    end
    bus_idle();
  endtask

  task automatic test_invalid();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== 32'h0 || er !== 1'b1 || cyc !== 1) begin
      n_err++;
      $display("FAIL invalid_read: got %h err=%b cyc=%0d want 0/1/1", rd, er, cyc);
    end
    bus_idle();
    xfer(0, 1'b1, 8'h02, 32'hFFFF_FFFF, 4'hF, rd, er, cyc, srdy);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_err++;
      $display("FAIL misaligned_write: got err=%b rd=%h want 1/0", er, rd);
    end
    bus_idle();
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== m0[0] || er !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_nomod: got %h err=%b want %h/0", rd, er, m0[0]);
    end
    bus_idle();
  endtask

  task automatic test_read_only();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    xfer(0, 1'b1, 8'h1C, 32'h0000_1234, 4'hF, rd, er, cyc, srdy);
    n_cmp++;
    if (er !== 1'b1) begin
      n_err++;
      $display("FAIL ro_write_err: got %b want 1", er);
    end
    bus_idle();
    xfer(0, 1'b0, 8'h1C, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== RST0 || er !== 1'b0) begin
      n_err++;
      $display("FAIL ro_read: got %h err=%b want %h/0", rd, er, RST0);
    end
    bus_idle();
  endtask

  task automatic test_missing_setup();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    int          seen;
    seen = 0;
    @(negedge pclk);
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (if0.pready !== 1'b0) seen++;
      @(negedge pclk);
    end
    psel0 = 1'b0; penable = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL nosetup_pready: got %0d ready cycles want 0", seen);
    end
    xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== m0[3]) begin
      n_err++;
      $display("FAIL nosetup_nomod: got %h want %h", rd, m0[3]);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    int          seen;
    seen = 0;
    @(negedge pclk);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 0; i < W1 - 1; i++) begin
      #1;
      if (if1.pready !== 1'b0) seen++;
      @(negedge pclk);
    end
    psel1 = 1'b0; penable = 1'b0;
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_early_ready: got %0d ready cycles want 0", seen);
    end
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== m1[3] || cyc !== W1 + 1) begin
      n_err++;
      $display("FAIL abort_nomod: got %h cyc=%0d want %h/%0d", rd, cyc, m1[3], W1 + 1);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd;
    logic        er, eer, srdy;
    int          cyc;
    logic [7:0]  addrs [3];
    bit          wrs   [3];
    logic [31:0] datas [3];
    addrs[0] = 8'h14; wrs[0] = 1'b1; datas[0] = 32'hA1B2_C3D4;
    addrs[1] = 8'h14; wrs[1] = 1'b0; datas[1] = 32'h0;
    addrs[2] = 8'h18; wrs[2] = 1'b1; datas[2] = 32'h0F0F_F0F0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        xfer(d, wrs[i], addrs[i], datas[i], 4'hF, rd, er, cyc, srdy);
        model_xfer(d, wrs[i], addrs[i], datas[i], 4'hF, erd, eer);
        n_cmp++;
        if (rd !== erd || er !== eer || cyc !== ((d == 0) ? W0 + 1 : W1 + 1) || srdy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b d%0d t%0d: got %h/%b cyc=%0d srdy=%b want %h/%b", d, i, rd, er, cyc, srdy, erd, eer);
        end
      end
      bus_idle();
    end
  endtask

  task automatic test_pstrb();
    logic [31:0] rd, erd;
    logic        er, eer, srdy;
    int          cyc;
    xfer(0, 1'b1, 8'h10, 32'h1122_3344, 4'hF, rd, er, cyc, srdy);
    model_xfer(0, 1'b1, 8'h10, 32'h1122_3344, 4'hF, erd, eer);
    bus_idle();
    xfer(0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, rd, er, cyc, srdy);
    model_xfer(0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101, erd, eer);
    bus_idle();
    xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
`ifdef APB_REGFILE_PSTRB_EN
    if (rd !== 32'h11BB_33DD) begin
      n_err++;
      $display("FAIL pstrb_merge: got %h want 11bb33dd", rd);
    end
`else
    if (rd !== 32'hAABB_CCDD) begin
      n_err++;
      $display("FAIL pstrb_ignored: got %h want aabbccdd", rd);
    end
`endif
    bus_idle();
`ifdef APB_REGFILE_PSTRB_EN
    xfer(0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0, rd, er, cyc, srdy);
    model_xfer(0, 1'b1, 8'h10, 32'hFFFF_FFFF, 4'h0, erd, eer);
    n_cmp++;
    if (er !== 1'b0) begin
      n_err++;
      $display("FAIL pstrb_zero_err: got %b want 0", er);
    end
    bus_idle();
    xfer(0, 1'b0, 8'h10, 32'h0, 4'h2, rd, er, cyc, srdy);
    n_cmp++;
    if (er !== 1'b1 || rd !== 32'h11BB_33DD) begin
      n_err++;
      $display("FAIL pstrb_read_err: got %h/%b want 11bb33dd/1", rd, er);
    end
    bus_idle();
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd;
    logic        er, eer, srdy;
    logic [7:0]  addr;
    logic [3:0]  strb;
    int          cyc, d;
    bit          wr;
    for (int n = 0; n < 80; n++) begin
      d    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 35));
      wd   = $urandom;
      strb = 4'($urandom_range(0, 15));
      xfer(d, wr, addr, wd, strb, rd, er, cyc, srdy);
      model_xfer(d, wr, addr, wd, strb, erd, eer);
      n_cmp++;
      if (rd !== erd || er !== eer || cyc !== ((d == 0) ? W0 + 1 : W1 + 1)) begin
        n_err++;
        $display("FAIL random n%0d d%0d wr%0d a%h: got %h/%b cyc=%0d want %h/%b", n, d, wr, addr, rd, er, cyc, erd, eer);
      end
      if ($urandom_range(0, 1) == 0) bus_idle();
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er, srdy;
    int          cyc;
    bit          got;
    @(negedge pclk);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
    pwdata = 32'h0000_00FF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    got = 1'b0; cyc = 0;
    while (!got && cyc < 40) begin
      #1;
      cyc++;
      if (if1.pready) got = 1'b1;
      else @(negedge pclk);
    end
    n_cmp++;
    if (cyc !== W1 + 1) begin
      n_err++;
      $display("FAIL rstmid_reach: got cyc=%0d want %0d", cyc, W1 + 1);
    end
    preset_n = 1'b0;
    #1;
    n_cmp++;
    if ({if1.pready, if1.pslverr} !== 2'b00 || if1.prdata !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %b/%h want 00/0", {if1.pready, if1.pslverr}, if1.prdata);
    end
    model_reset();
    @(negedge pclk);
    psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== RST1 || er !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_nowrite: got %h/%b want %h/0", rd, er, RST1);
    end
    bus_idle();
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, cyc, srdy);
    n_cmp++;
    if (rd !== RST0) begin
      n_err++;
      $display("FAIL rstmid_other: got %h want %h", rd, RST0);
    end
    bus_idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_wait_states();
    test_invalid();
    test_read_only();
    test_missing_setup();
    test_abort();
    test_back_to_back();
    test_pstrb();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
